// File: rtl/mux_2_to_1_pkg.sv
// mux_2_to_1_pkg: shared width default and select encodings for the registered word selector.
package mux_2_to_1_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;
endpackage

// File: rtl/mux_2_to_1_skid.sv
// mux_2_to_1_skid: two-entry valid/ready skid buffer (main drives out, skid absorbs one stalled word).
module mux_2_to_1_skid #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_ready_q, in_ready_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         acc, xfer, load_main;
  always_comb begin
    acc          = in_valid && in_ready_q;
    xfer         = main_valid_q && out_ready;
    load_main    = !main_valid_q || xfer;
    main_valid_d = load_main ? (skid_valid_q || acc) : 1'b1;
    main_data_d  = !load_main ? main_data_q : skid_valid_q ? skid_data_q : acc ? in_data : main_data_q;
    skid_valid_d = (acc && !load_main) ? 1'b1 : xfer ? 1'b0 : skid_valid_q;
    skid_data_d  = (acc && !load_main) ? in_data : skid_data_q;
    in_ready_d   = !skid_valid_d;
  end
  // in_ready stays low while reset is held and rises on the first edge after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
endmodule

// File: rtl/mux_2_to_1.sv
// mux_2_to_1: selects a (sel=0) or b (sel=1) at acceptance and presents it through a skid-buffered output.
// Optional MUX_2_TO_1_PARITY_EN adds out_parity, stored alongside each word.
module mux_2_to_1
  import mux_2_to_1_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
`ifdef MUX_2_TO_1_PARITY_EN
  output logic             out_parity,
`endif
  input  logic             out_ready
);
`ifdef MUX_2_TO_1_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif
  logic [WIDTH-1:0] word;
  logic [DW-1:0]    payload, out_word;
  always_comb begin
    word = (sel == SEL_B) ? b : a;
`ifdef MUX_2_TO_1_PARITY_EN
    payload = {^word, word};
`else
    payload = word;
`endif
  end
  mux_2_to_1_skid #(.W(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (payload),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );
  assign out = out_word[WIDTH-1:0];
`ifdef MUX_2_TO_1_PARITY_EN
  assign out_parity = out_word[WIDTH];
`endif
endmodule

// File: tb/tb_mux_2_to_1.sv
// tb_mux_2_to_1: vector table, reset corner case and randomized run against a queue model.
module tb_mux_2_to_1;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0, b = '0, out;
  logic        sel = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
`ifdef MUX_2_TO_1_PARITY_EN
  logic        out_parity;
`endif
  int          checks = 0, failures = 0;

  mux_2_to_1 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
`ifdef MUX_2_TO_1_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        sel, iv, ordy;
    logic [15:0] eo;
    logic        ev, eir;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_par();
`ifdef MUX_2_TO_1_PARITY_EN
    if (out_valid === 1'b1) chk("parity", 32'(out_parity), 32'(^out));
`endif
  endtask

  task automatic drive(input logic [15:0] ia, input logic [15:0] ib, input logic is, input logic iv, input logic ordy);
    a = ia; b = ib; sel = is; in_valid = iv; out_ready = ordy;
  endtask

  logic [15:0] q[$];
  logic [15:0] w;
  bit          push, pop;

  initial begin
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
`ifdef MUX_2_TO_1_PARITY_EN
    chk("rst_parity", 32'(out_parity), 0);
`endif
    #4 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);

    tv.push_back('{16'hF0F0, 16'h0F0F, 1'b0, 1'b1, 1'b1, 16'hF0F0, 1'b1, 1'b1});
    tv.push_back('{16'hF0F0, 16'h0F0F, 1'b1, 1'b1, 1'b1, 16'h0F0F, 1'b1, 1'b1});
    tv.push_back('{16'hF0F0, 16'h0F0F, 1'b0, 1'b1, 1'b1, 16'hF0F0, 1'b1, 1'b1});
    tv.push_back('{16'hF0F0, 16'h0F0F, 1'b1, 1'b1, 1'b1, 16'h0F0F, 1'b1, 1'b1});
    tv.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1});
    tv.push_back('{16'hF0F0, 16'h0F0F, 1'b0, 1'b1, 1'b0, 16'hF0F0, 1'b1, 1'b1});
    tv.push_back('{16'hF0F0, 16'h0F0F, 1'b1, 1'b1, 1'b0, 16'hF0F0, 1'b1, 1'b0});
    tv.push_back('{16'h1234, 16'h0F0F, 1'b0, 1'b1, 1'b0, 16'hF0F0, 1'b1, 1'b0});
    tv.push_back('{16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b1, 16'h0F0F, 1'b1, 1'b1});
    tv.push_back('{16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1});
    tv.push_back('{16'hAAAA, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b1});
    tv.push_back('{16'h5555, 16'h3333, 1'b1, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b1});
    tv.push_back('{16'h7777, 16'h3333, 1'b0, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b1});
    tv.push_back('{16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b1});
    tv.push_back('{16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1});
    tv.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1});
    foreach (tv[i]) begin
      drive(tv[i].a, tv[i].b, tv[i].sel, tv[i].iv, tv[i].ordy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tv[i].ev));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tv[i].eir));
      if (tv[i].ev) chk($sformatf("vec%0d_out", i), 32'(out), 32'(tv[i].eo));
      chk_par();
    end

    drive(16'hBEEF, 16'hCAFE, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    sel = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_out", 32'(out), 32'h0000BEEF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_out", 32'(out), 0);
    chk("async_rst_in_ready", 32'(in_ready), 0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 1);
    chk("rel_out_valid", 32'(out_valid), 0);

    for (int c = 0; c < 600; c++) begin
      chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) chk("rnd_out", 32'(out), 32'(q[0]));
      chk_par();
      drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0));
      w    = sel ? b : a;
      push = in_valid && (q.size() < 2);
      pop  = out_ready && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(w);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
